// File: rtl/dma_tx.sv
`timescale 1ns/1ps
// DMA transmit engine: takes the bus, reads NUM_BYTES from RAM at BASE_ADDR and streams them to the UART.
// Start-to-first-TX_Valid is 4 cycles; holds the bus and TX_Valid while TX_Ready is low (no byte dropped).
module dma_tx #(
  parameter int            AW        = 8,
  parameter int            DW        = 8,
  parameter logic [AW-1:0] BASE_ADDR = 8'h04,
  parameter int            NUM_BYTES = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Enable,
  input  logic          TX_Start,
  input  logic          Bus_grant,
  input  logic [DW-1:0] Databus,
  output logic [AW-1:0] Address,
  output logic          Cs,
  output logic          Bus_req,
  output logic [DW-1:0] TX_Data,
  output logic          TX_Valid,
  input  logic          TX_Ready,
  output logic          Dma_Tx_Ready
);

  if (NUM_BYTES < 1 || NUM_BYTES > 255) begin : g_bad_num_bytes
    $error("dma_tx: NUM_BYTES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_LATCH,
    S_SEND
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_idx;
  logic [7:0]    w_idx_next;
  logic [DW-1:0] r_tx_data;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
      // RAM data is valid the cycle after Cs, which is exactly the LATCH cycle
      if (r_state == S_LATCH) begin
        r_tx_data <= Databus;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      S_IDLE: begin
        if (TX_Start && Enable) begin
          w_next     = S_REQ;
          w_idx_next = '0;
        end
      end
      S_REQ: begin
        if (Bus_grant) w_next = S_READ;
      end
      S_READ: begin
        if (Bus_grant) w_next = S_LATCH;
      end
      S_LATCH: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (TX_Ready) begin
          if (r_idx == LAST_IDX) begin
            w_next = S_IDLE;
          end else begin
            w_next     = S_READ;
            w_idx_next = r_idx + 8'd1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Cs follows the grant directly so a lost grant never issues a read
  always_comb begin
    Address = '0;
    Cs      = 1'b0;
    if (r_state == S_READ) begin
      Address = BASE_ADDR + AW'(r_idx);
      Cs      = Bus_grant;
    end
  end

  assign Bus_req      = (r_state != S_IDLE);
  assign TX_Valid     = (r_state == S_SEND);
  assign Dma_Tx_Ready = (r_state == S_IDLE);
  assign TX_Data      = r_tx_data;

endmodule
